// File: rtl/mod_mult_pkg.sv
// rtl/mod_mult_pkg.sv - shared types and constant helpers for the serial modular multiplier
package mod_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  // Counter width; never zero so a single-digit configuration still has a register.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mod_digit_step.sv
// rtl/mod_digit_step.sv - one Horner digit step: (acc<<D + a*digit) reduced below MOD
module mod_digit_step
  import mod_mult_pkg::*;
#(
  parameter int W   = 10,
  parameter int MOD = 997,
  parameter int D   = 3
) (
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] a_i,
  input  logic [D-1:0] digit_i,
  output logic [W-1:0] acc_o
);

  localparam int TW   = W + D + 1;
  localparam int KMAX = (1 << (D + 1)) - 1;

  logic [TW-1:0] a_ext;
  logic [TW-1:0] d_ext;
  logic [TW-1:0] t;
  logic [TW-1:0] multiple;
  logic [TW-1:0] sub;

  // Ladder walks k*MOD upward; the last multiple not exceeding t is subtracted.
  always_comb begin
    a_ext    = TW'(a_i);
    d_ext    = TW'(digit_i);
    t        = (TW'(acc_i) << D) + a_ext * d_ext;
    multiple = '0;
    sub      = '0;
    for (int k = 1; k <= KMAX; k++) begin
      multiple = multiple + TW'(MOD);
      if (t >= multiple) sub = multiple;
    end
    acc_o = W'(t - sub);
  end

endmodule

// File: rtl/mod_mult_serial.sv
// rtl/mod_mult_serial.sv - digit-serial MSB-first modular multiplier with valid/ready handshakes
module mod_mult_serial
  import mod_mult_pkg::*;
#(
  parameter int W   = 10,
  parameter int MOD = 997,
  parameter int D   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_z
);

  localparam int ND = ceil_div(W, D);
  localparam int CW = clog2_min1(ND);
  localparam int BW = ND * D;
  localparam logic [W-1:0]  MOD_W    = W'(MOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(ND - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [BW-1:0] b_ext;
  logic [BW-1:0] b_shift;
  logic [D-1:0]  digit;
  logic [W-1:0]  acc_step;

  assign b_ext   = BW'(b_q);
  assign b_shift = b_ext >> (D * int'(cnt_q));
  assign digit   = b_shift[D-1:0];

  mod_digit_step #(
    .W   (W),
    .MOD (MOD),
    .D   (D)
  ) u_step (
    .acc_i   (acc_q),
    .a_i     (a_q),
    .digit_i (digit),
    .acc_o   (acc_step)
  );

  // One conditional subtraction suffices because MOD exceeds half the input range.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = (in_a >= MOD_W) ? in_a - MOD_W : in_a;
          b_d     = (in_b >= MOD_W) ? in_b - MOD_W : in_b;
          acc_d   = '0;
          cnt_d   = CNT_LAST;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_step;
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_z     = acc_q;

endmodule

// File: tb/tb_mod_mult_serial.sv
// tb/tb_mod_mult_serial.sv - directed and randomised checks of mod_mult_serial in three configurations
module tb_mod_mult_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] vld;
  logic [2:0] rdy;
  logic [9:0] a [3];
  logic [9:0] b [3];
  wire  [2:0] ir;
  wire  [2:0] ov;
  wire  [9:0] z0;
  wire  [7:0] z1;
  wire  [9:0] z2;

  int tests = 0;
  int fails = 0;

  mod_mult_serial #(.W(10), .MOD(997), .D(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(ir[0]),
    .in_a(a[0]), .in_b(b[0]), .out_valid(ov[0]), .out_ready(rdy[0]), .out_z(z0)
  );

  mod_mult_serial #(.W(8), .MOD(251), .D(2)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(ir[1]),
    .in_a(a[1][7:0]), .in_b(b[1][7:0]), .out_valid(ov[1]), .out_ready(rdy[1]), .out_z(z1)
  );

  mod_mult_serial #(.W(10), .MOD(997), .D(10)) u_full (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(ir[2]),
    .in_a(a[2]), .in_b(b[2]), .out_valid(ov[2]), .out_ready(rdy[2]), .out_z(z2)
  );

  function automatic int mod_of(input int c);
    return (c == 1) ? 251 : 997;
  endfunction

  function automatic int width_of(input int c);
    return (c == 1) ? 8 : 10;
  endfunction

  function automatic logic [9:0] z_of(input int c);
    case (c)
      0:       return z0;
      1:       return {2'b00, z1};
      default: return z2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic accept0(input logic [9:0] ai, input logic [9:0] bi, input string tag);
    vld[0] = 1'b1;
    a[0]   = ai;
    b[0]   = bi;
    chk({tag, " in_ready before accept"}, 32'(ir[0]), 32'd1);
    step();
    vld[0] = 1'b0;
    chk({tag, " in_ready after accept"}, 32'(ir[0]), 32'd0);
  endtask

  task automatic wait_res0(input logic [9:0] ez, input string tag);
    int lat;
    lat = 0;
    while (!ov[0] && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd4);
    chk({tag, " out_z"}, 32'(z0), 32'(ez));
  endtask

  task automatic drain0(input string tag);
    rdy[0] = 1'b1;
    step();
    rdy[0] = 1'b0;
    chk({tag, " out_valid after handshake"}, 32'(ov[0]), 32'd0);
    chk({tag, " in_ready after handshake"}, 32'(ir[0]), 32'd1);
  endtask

  task automatic do_op(input logic [9:0] ai, input logic [9:0] bi, input logic [9:0] ez, input string tag);
    accept0(ai, bi, tag);
    wait_res0(ez, tag);
    drain0(tag);
  endtask

  task automatic rand_run(input int cfg, input int n);
    int exp_q[$];
    int sent, got, cyc, m, msk, ai, bi;
    sent = 0;
    got  = 0;
    cyc  = 0;
    m    = mod_of(cfg);
    msk  = (1 << width_of(cfg)) - 1;
    while (got < n && cyc < 20000) begin
      ai       = int'($urandom) & msk;
      bi       = int'($urandom) & msk;
      vld[cfg] = (sent < n) && ($urandom_range(3) != 0);
      a[cfg]   = 10'(ai);
      b[cfg]   = 10'(bi);
      rdy[cfg] = ($urandom_range(2) != 0);
      if (vld[cfg] && ir[cfg]) begin
        exp_q.push_back(((ai % m) * (bi % m)) % m);
        sent++;
      end
      if (ov[cfg] && rdy[cfg]) begin
        if (exp_q.size() == 0) chk("rand unexpected result", 32'd1, 32'd0);
        else                   chk("rand out_z", 32'(z_of(cfg)), 32'(exp_q.pop_front()));
        got++;
      end
      step();
      cyc++;
    end
    vld[cfg] = 1'b0;
    rdy[cfg] = 1'b0;
    chk("rand results received", 32'(got), 32'(n));
    chk("rand results outstanding", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int seen;
    vld = '0;
    rdy = '0;
    for (int i = 0; i < 3; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset in_ready", 32'(ir[0]), 32'd1);
    chk("reset out_valid", 32'(ov[0]), 32'd0);
    chk("reset out_z", 32'(z0), 32'd0);
    rst_n = 1'b1;
    step();

    rdy[0] = 1'b1;
    step();
    step();
    chk("idle out_ready ignored in_ready", 32'(ir[0]), 32'd1);
    chk("idle out_ready ignored out_valid", 32'(ov[0]), 32'd0);
    rdy[0] = 1'b0;

    do_op(10'd996, 10'd996, 10'd1, "996x996");
    do_op(10'd2, 10'd500, 10'd3, "2x500");
    do_op(10'd1000, 10'd2, 10'd6, "1000x2");
    do_op(10'd0, 10'd996, 10'd0, "0x996");
    do_op(10'd1023, 10'd1023, 10'd676, "1023x1023");

    accept0(10'd10, 10'd20, "stall");
    wait_res0(10'd200, "stall");
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall out_z held", 32'(z0), 32'd200);
      chk("stall in_ready low", 32'(ir[0]), 32'd0);
      chk("stall out_valid held", 32'(ov[0]), 32'd1);
    end
    rdy[0] = 1'b1;
    step();
    rdy[0] = 1'b0;
    chk("stall release in_ready", 32'(ir[0]), 32'd1);
    accept0(10'd3, 10'd4, "back-to-back");
    wait_res0(10'd12, "back-to-back");
    drain0("back-to-back");

    accept0(10'd500, 10'd500, "abort");
    step();
    rst_n = 1'b0;
    #1;
    chk("abort in_ready", 32'(ir[0]), 32'd1);
    chk("abort out_valid", 32'(ov[0]), 32'd0);
    chk("abort out_z", 32'(z0), 32'd0);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ov[0]) seen++;
    end
    chk("abort no result emitted", 32'(seen), 32'd0);
    do_op(10'd3, 10'd5, 10'd15, "after abort");

    rand_run(0, 300);
    rand_run(1, 300);
    rand_run(2, 300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
